rom_loader: RTL
===============

Name: rom_loader

Overview:
- Boot-time reader for the generated program ROM.
- Walks ROM byte addresses from 0 upward and packs bytes little-endian into 32-bit words.
- Writes each word into main memory through a valid/ready write port.
- Stops when the ROM raises its done flag, then releases the core from reset via `finished`.

Parameters:
- MEM_BASE, 32'd0, memory word address that receives ROM bytes 0..3.
- MAX_BYTES, 32'd65536, safety limit: loading ends if rom_address reaches this value without rom_done.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- rom_address  output  32  byte address to ROM; driven from a register.
- rom_byte  input  8  combinational ROM data for rom_address.
- rom_done  input  1  ROM end marker; the byte at this address is not part of the image.
- mem_address  output  32  word address of the write.
- mem_data  output  32  packed word.
- mem_write  output  1  write valid.
- mem_ready  input  1  memory accepts the write when high with mem_write.
- busy  output  1  high in FETCH or WRITE.
- finished  output  1  high in DONE.
- byte_count  output  32  bytes loaded so far.

Behaviour:
- Reset (async, reset_n low): all of the following are 0 — rom_address, mem_address, mem_data, mem_write, busy, finished, byte_count, lane, flush flag. State becomes IDLE.
- States: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - start=1 → FETCH, with rom_address=0, byte_count=0, lane=0, mem_address=MEM_BASE, mem_data=0.
  - start=0 → stay in IDLE.
- FETCH (one byte per cycle; ROM is combinational from a registered address, so data is valid in the same cycle):
  - If rom_done=1 or rom_address==MAX_BYTES:
    - lane≠0 → set flush, go to WRITE. Unfilled upper lanes stay 0.
    - lane=0 → go to DONE.
  - Otherwise:
    - mem_data[8*lane+7:8*lane] ← rom_byte.
    - rom_address+1, byte_count+1, lane+1.
    - If lane was 3 → go to WRITE.
- WRITE:
  - mem_write=1; mem_data and mem_address are held stable until accepted.
  - mem_ready=1 at a rising edge = accepted. On acceptance:
    - mem_write drops next cycle.
    - mem_address+1, lane=0, mem_data=0.
    - Next state is DONE if flush was set, else FETCH.
  - mem_ready=0 → stay; no timeout.
- DONE:
  - finished=1; rom_address, mem_address and byte_count hold their values.
  - start=1 → restart exactly as from IDLE; finished drops next cycle.
- start is ignored in FETCH and WRITE.
- Timing: a full word costs 4 FETCH cycles plus at least 1 WRITE cycle. There are no idle bubbles between FETCH and WRITE.
- Word count after a load equals ceil(bytes/4). byte_count excludes the done-marker byte.
- rom_done already high at address 0 → FETCH to DONE in 1 cycle, no writes, byte_count=0.
- Wrap-around: rom_address never exceeds MAX_BYTES. mem_address wraps modulo 2^32.
- reset_n asserted mid-load: immediate return to IDLE. The partial word is discarded and mem_write drops asynchronously.

Test Plan:
1. Bench ROM holds 90 bytes beginning 14,20,0,0,0,0,1,0,0,0,20,97, with rom_done at address 90. Pulse start with mem_ready tied high → exactly 23 writes. Word 0 = 0x0000140E, word 1 = 0x00010000, word 2 = 0x61140000. finished=1, byte_count=90, rom_address=90.
2. Same image, mem_ready low for 5 cycles on the first write → mem_write, mem_address=MEM_BASE and mem_data=0x0000140E all held stable; rom_address stays 4 until acceptance.
3. Image of 6 bytes 1..6, done at address 6 → writes 0x04030201 then 0x00000605 (zero-padded flush). byte_count=6.
4. rom_done high at address 0 → no mem_write ever. finished=1 two cycles after the start pulse, byte_count=0.
5. reset_n pulsed low during the third FETCH → all outputs 0 immediately, no write issued. A later start reloads from address 0 correctly.
6. start pulsed during WRITE is ignored. start pulsed in DONE performs a second identical load with matching write addresses and data.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-time program loader: streams ROM bytes, packs them little-endian into
// 32-bit words and writes them to main memory, then raises `finished`.
module rom_loader #(
  parameter logic [31:0] MEM_BASE  = 32'd0,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte,
  input  logic        rom_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic        busy,
  output logic        finished,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t      state, stateNext;
  logic [31:0] romAddressNext;
  logic [31:0] memAddressNext;
  logic [31:0] memDataNext;
  logic [31:0] byteCountNext;
  logic [1:0]  lane, laneNext;
  logic        flush, flushNext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rom_address <= 32'd0;
      mem_address <= 32'd0;
      mem_data    <= 32'd0;
      byte_count  <= 32'd0;
      lane        <= 2'd0;
      flush       <= 1'b0;
    end else begin
      state       <= stateNext;
      rom_address <= romAddressNext;
      mem_address <= memAddressNext;
      mem_data    <= memDataNext;
      byte_count  <= byteCountNext;
      lane        <= laneNext;
      flush       <= flushNext;
    end
  end

  // The end-of-image check comes before the byte capture, so the done-marker
  // byte is never packed and rom_address can never step past MAX_BYTES.
  always_comb begin
    stateNext      = state;
    romAddressNext = rom_address;
    memAddressNext = mem_address;
    memDataNext    = mem_data;
    byteCountNext  = byte_count;
    laneNext       = lane;
    flushNext      = flush;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext      = FETCH;
          romAddressNext = 32'd0;
          byteCountNext  = 32'd0;
          laneNext       = 2'd0;
          memAddressNext = MEM_BASE;
          memDataNext    = 32'd0;
          flushNext      = 1'b0;
        end
      end

      FETCH: begin
        if (rom_done || (rom_address == MAX_BYTES)) begin
          if (lane != 2'd0) begin
            flushNext = 1'b1;
            stateNext = WRITE;
          end else begin
            stateNext = DONE;
          end
        end else begin
          memDataNext[{lane, 3'b000} +: 8] = rom_byte;
          romAddressNext = rom_address + 32'd1;
          byteCountNext  = byte_count + 32'd1;
          laneNext       = lane + 2'd1;
          if (lane == 2'd3) begin
            stateNext = WRITE;
          end
        end
      end

      WRITE: begin
        if (mem_ready) begin
          memAddressNext = mem_address + 32'd1;
          laneNext       = 2'd0;
          memDataNext    = 32'd0;
          flushNext      = 1'b0;
          stateNext      = flush ? DONE : FETCH;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so a reset removes mem_write at once.
  assign mem_write = (state == WRITE);
  assign busy      = (state == FETCH) || (state == WRITE);
  assign finished  = (state == DONE);

endmodule
